// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator-processor control FSM.
// Covers opcodes, state codes, ALU operations and the datapath control-line values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ILLEGAL = 4'd0,
        OP_LOAD    = 4'd1,
        OP_STORE   = 4'd2,
        OP_COPY    = 4'd3,
        OP_JUMP    = 4'd4,
        OP_ADD     = 4'd5,
        OP_SUB     = 4'd6,
        OP_MUL     = 4'd7,
        OP_DIV     = 4'd8,
        OP_CLR     = 4'd9,
        OP_INC     = 4'd10,
        OP_DEC     = 4'd11,
        OP_LOADK   = 4'd12,
        OP_JMPZ    = 4'd13,
        OP_NOP     = 4'd14,
        OP_END     = 4'd15
    } opcode_t;

    // Execute states reuse the opcode value so state_dbg shows the instruction directly.
    typedef enum logic [7:0] {
        S_LOAD   = 8'd1,
        S_STORE  = 8'd2,
        S_COPY   = 8'd3,
        S_JUMP   = 8'd4,
        S_ADD    = 8'd5,
        S_SUB    = 8'd6,
        S_MUL    = 8'd7,
        S_DIV    = 8'd8,
        S_CLR    = 8'd9,
        S_INC    = 8'd10,
        S_DEC    = 8'd11,
        S_LOADK  = 8'd12,
        S_JMPZ   = 8'd13,
        S_NOP    = 8'd14,
        S_END    = 8'd15,
        S_START  = 8'd16,
        S_FETCH1 = 8'd17,
        S_FETCH2 = 8'd18,
        S_ADD2   = 8'd19,
        S_SUB2   = 8'd20,
        S_MUL2   = 8'd21,
        S_DIV2   = 8'd22,
        S_COPY2  = 8'd23,
        S_LOAD2  = 8'd24,
        S_STORE2 = 8'd25,
        S_ERROR  = 8'd26
    } state_t;

    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_MUL   = 4'b0011;
    localparam logic [3:0] ALU_DIV   = 4'b0100;
    localparam logic [3:0] ALU_COPY  = 4'b0101;
    localparam logic [3:0] ALU_LOADK = 4'b0110;
    localparam logic [3:0] ALU_INC   = 4'b0111;
    localparam logic [3:0] ALU_DEC   = 4'b1000;
    localparam logic [3:0] ALU_CLR   = 4'b1001;

    localparam logic [1:0] MAR_HOLD  = 2'b00;
    localparam logic [1:0] MAR_AC    = 2'b01;
    localparam logic [1:0] MAR_READ  = 2'b10;
    localparam logic [1:0] MAR_WRITE = 2'b11;

    localparam logic [1:0] MDR_HOLD = 2'b00;
    localparam logic [1:0] MDR_DRAM = 2'b01;
    localparam logic [1:0] MDR_BUS  = 2'b10;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

    localparam logic [1:0] IDC_NONE = 2'b00;
    localparam logic [1:0] IDC_INC  = 2'b01;
    localparam logic [1:0] IDC_DEC  = 2'b10;
    localparam logic [1:0] IDC_CLR  = 2'b11;

    localparam logic [3:0] SRC_CONST = 4'b1011;
    localparam logic [3:0] SRC_AC    = 4'b0001;
    localparam logic [3:0] SRC_RR    = 4'b0010;
    localparam logic [2:0] DST_AC    = 3'b001;
    localparam logic [2:0] DST_MDR   = 3'b101;

    function automatic state_t exec_state(input logic [3:0] op);
        return state_t'({4'b0000, op});
    endfunction

endpackage

// File: rtl/control_fsm_param_if.sv
// Control/status bundle between the control FSM (master) and the datapath/memory side (slave).
interface control_fsm_param_if #(
    parameter int INSTR_W = 16,
    parameter int SRC_W   = 4,
    parameter int DST_W   = 3,
    parameter int ALU_W   = 4
);
    logic               enable_processor;
    logic [INSTR_W-1:0] instruction;
    logic               zero_flag;
    logic               mem_ready;
    logic               load_instruction;
    logic [ALU_W-1:0]   ALU_control;
    logic [SRC_W-1:0]   select_source;
    logic [DST_W-1:0]   select_destination;
    logic [1:0]         IDC_control;
    logic [1:0]         MDR_control;
    logic [1:0]         MAR_control;
    logic [1:0]         PC_control;
    logic               write_DRAM;
    logic               done;
    logic               illegal_opcode;
    logic               mem_error;
    logic [7:0]         state_dbg;

    modport master (
        input  enable_processor, instruction, zero_flag, mem_ready,
        output load_instruction, ALU_control, select_source, select_destination,
               IDC_control, MDR_control, MAR_control, PC_control, write_DRAM,
               done, illegal_opcode, mem_error, state_dbg
    );

    modport slave (
        output enable_processor, instruction, zero_flag, mem_ready,
        input  load_instruction, ALU_control, select_source, select_destination,
               IDC_control, MDR_control, MAR_control, PC_control, write_DRAM,
               done, illegal_opcode, mem_error, state_dbg
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts falling edges spent waiting on DRAM; expired marks the MEM_TIMEOUT-th wait edge.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/control_fsm_param.sv
// Second-generation accumulator-processor control FSM: fetch/decode/execute sequencing,
// registered datapath control lines, DRAM ready handshake with timeout, sticky error flags.
module control_fsm_param
    import ctrl_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int OPCODE_W    = 4,
    parameter int SRC_W       = 4,
    parameter int DST_W       = 3,
    parameter int ALU_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    control_fsm_param_if.master bus
);
    typedef struct packed {
        logic             load_instruction;
        logic [ALU_W-1:0] alu_control;
        logic [SRC_W-1:0] select_source;
        logic [DST_W-1:0] select_destination;
        logic [1:0]       idc_control;
        logic [1:0]       mdr_control;
        logic [1:0]       mar_control;
        logic [1:0]       pc_control;
        logic             write_dram;
        logic             done;
    } ctrl_t;

    state_t              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [OPCODE_W-1:0] op_q;
    logic [SRC_W-1:0]    src_q;
    logic [DST_W-1:0]    dst_q;
    logic                illegal_q, mem_error_q;
    logic                set_illegal, set_mem_error;
    logic                waiting, timer_en, timer_clr, timer_expired;
    logic                instr_unused;

    // Bits between the source and destination fields carry no control meaning.
    assign instr_unused = ^bus.instruction;

    assign waiting   = (state_q == S_LOAD2) || (state_q == S_STORE2);
    assign timer_en  = waiting && !bus.mem_ready;
    assign timer_clr = !waiting || bus.mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(timer_expired)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        set_illegal   = 1'b0;
        set_mem_error = 1'b0;
        case (state_q)
            S_START:  if (bus.enable_processor) state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                if (op_q == '0) begin
                    state_d     = S_ERROR;
                    set_illegal = 1'b1;
                end else begin
                    state_d = exec_state(4'(op_q));
                end
            end
            S_ADD:    state_d = S_ADD2;
            S_SUB:    state_d = S_SUB2;
            S_MUL:    state_d = S_MUL2;
            S_DIV:    state_d = S_DIV2;
            S_COPY:   state_d = S_COPY2;
            S_LOAD:   state_d = S_LOAD2;
            S_STORE:  state_d = S_STORE2;
            S_LOAD2, S_STORE2: begin
                // A ready arriving on the timeout edge still completes the access.
                if (bus.mem_ready) begin
                    state_d = S_FETCH1;
                end else if (timer_expired) begin
                    state_d       = S_ERROR;
                    set_mem_error = 1'b1;
                end
            end
            S_JUMP, S_JMPZ, S_NOP, S_CLR, S_INC, S_DEC, S_LOADK,
            S_ADD2, S_SUB2, S_MUL2, S_DIV2, S_COPY2: state_d = S_FETCH1;
            S_END, S_ERROR: state_d = state_q;
            default:  state_d = S_START;
        endcase
    end

    // Outputs are decoded from the state being entered so they register on the entry edge.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH1: ctrl_d.load_instruction = 1'b1;
            S_FETCH2: ctrl_d.pc_control = PC_INC;
            S_ADD, S_SUB, S_COPY: ctrl_d.select_source = src_q;
            S_MUL, S_DIV: ctrl_d.select_source = SRC_W'(SRC_CONST);
            S_ADD2:   ctrl_d.alu_control = ALU_W'(ALU_ADD);
            S_SUB2:   ctrl_d.alu_control = ALU_W'(ALU_SUB);
            S_MUL2:   ctrl_d.alu_control = ALU_W'(ALU_MUL);
            S_DIV2:   ctrl_d.alu_control = ALU_W'(ALU_DIV);
            S_COPY2: begin
                if (dst_q == DST_W'(DST_AC)) begin
                    ctrl_d.alu_control = ALU_W'(ALU_COPY);
                end else if (dst_q == DST_W'(DST_MDR)) begin
                    ctrl_d.mdr_control        = MDR_BUS;
                    ctrl_d.select_destination = dst_q;
                end else begin
                    ctrl_d.select_destination = dst_q;
                end
            end
            S_LOADK:  ctrl_d.alu_control = ALU_W'(ALU_LOADK);
            S_JUMP:   ctrl_d.pc_control = PC_LOAD;
            S_JMPZ:   ctrl_d.pc_control = bus.zero_flag ? PC_LOAD : PC_HOLD;
            S_INC: begin
                if (src_q == SRC_W'(SRC_AC)) ctrl_d.alu_control = ALU_W'(ALU_INC);
                else                         ctrl_d.idc_control = IDC_INC;
            end
            S_DEC: begin
                if (src_q == SRC_W'(SRC_AC)) ctrl_d.alu_control = ALU_W'(ALU_DEC);
                else                         ctrl_d.idc_control = IDC_DEC;
            end
            S_CLR: begin
                if (src_q == SRC_W'(SRC_AC)) ctrl_d.alu_control = ALU_W'(ALU_CLR);
                else                         ctrl_d.idc_control = IDC_CLR;
            end
            S_LOAD, S_STORE: begin
                if (src_q == SRC_W'(SRC_AC)) begin
                    ctrl_d.mar_control = MAR_AC;
                end else if (src_q == SRC_W'(SRC_RR)) begin
                    ctrl_d.mar_control = (state_d == S_LOAD) ? MAR_READ : MAR_WRITE;
                end
            end
            S_LOAD2:  ctrl_d.mdr_control = MDR_DRAM;
            S_STORE2: ctrl_d.write_dram = 1'b1;
            S_END:    ctrl_d.done = 1'b1;
            default:  ctrl_d = '0;
        endcase
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q     <= S_START;
            ctrl_q      <= '0;
            op_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            illegal_q   <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            // Fields are captured on entry to FETCH2 and dispatched one edge later.
            if (state_q == S_FETCH1) begin
                op_q  <= bus.instruction[INSTR_W-1 -: OPCODE_W];
                src_q <= bus.instruction[INSTR_W-OPCODE_W-1 -: SRC_W];
                dst_q <= bus.instruction[DST_W-1:0];
            end
            if (set_illegal)   illegal_q   <= 1'b1;
            if (set_mem_error) mem_error_q <= 1'b1;
        end
    end

    assign bus.load_instruction   = ctrl_q.load_instruction;
    assign bus.ALU_control        = ctrl_q.alu_control;
    assign bus.select_source      = ctrl_q.select_source;
    assign bus.select_destination = ctrl_q.select_destination;
    assign bus.IDC_control        = ctrl_q.idc_control;
    assign bus.MDR_control        = ctrl_q.mdr_control;
    assign bus.MAR_control        = ctrl_q.mar_control;
    assign bus.PC_control         = ctrl_q.pc_control;
    assign bus.write_DRAM         = ctrl_q.write_dram;
    assign bus.done               = ctrl_q.done;
    assign bus.illegal_opcode     = illegal_q;
    assign bus.mem_error          = mem_error_q;
    assign bus.state_dbg          = state_q;
endmodule

// File: tb/tb_control_fsm_param.sv
// Directed self-checking bench for control_fsm_param; expected values are hand-computed codes.
module tb_control_fsm_param;
    localparam int INSTR_W     = 16;
    localparam int OPCODE_W    = 4;
    localparam int SRC_W       = 4;
    localparam int DST_W       = 3;
    localparam int ALU_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    control_fsm_param_if #(
        .INSTR_W(INSTR_W), .SRC_W(SRC_W), .DST_W(DST_W), .ALU_W(ALU_W)
    ) bus ();

    control_fsm_param #(
        .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .SRC_W(SRC_W), .DST_W(DST_W),
        .ALU_W(ALU_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic expect_state(input string tag, input int code);
        tick();
        check(tag, 32'(bus.state_dbg), 32'(code));
    endtask

    initial begin
        reset                = 1'b1;
        bus.enable_processor = 1'b0;
        bus.instruction      = '0;
        bus.zero_flag        = 1'b0;
        bus.mem_ready        = 1'b0;

        tick();
        expect_state("reset_state", 16);
        check("reset_load_instr", 32'(bus.load_instruction), 0);
        check("reset_pc", 32'(bus.PC_control), 0);
        check("reset_flags", 32'({bus.done, bus.illegal_opcode, bus.mem_error, bus.write_DRAM}), 0);

        reset = 1'b0;
        expect_state("start_idle", 16);

        // ADD R2
        bus.instruction      = 16'h5200;
        bus.enable_processor = 1'b1;
        expect_state("add_fetch1", 17);
        check("add_load_instr", 32'(bus.load_instruction), 1);
        expect_state("add_fetch2", 18);
        check("add_pc_inc", 32'(bus.PC_control), 1);
        expect_state("add_exec", 5);
        check("add_src", 32'(bus.select_source), 32'b0010);
        expect_state("add2", 19);
        check("add2_alu", 32'(bus.ALU_control), 32'b0001);
        expect_state("add_back", 17);

        // JMPZ taken then not taken
        bus.instruction = 16'hD000;
        bus.zero_flag   = 1'b1;
        expect_state("jmpz1_fetch2", 18);
        expect_state("jmpz1_exec", 13);
        check("jmpz1_pc_load", 32'(bus.PC_control), 32'b10);
        expect_state("jmpz1_back", 17);
        bus.zero_flag = 1'b0;
        expect_state("jmpz0_fetch2", 18);
        expect_state("jmpz0_exec", 13);
        check("jmpz0_pc_hold", 32'(bus.PC_control), 32'b00);
        expect_state("jmpz0_back", 17);

        // MUL uses the constant source
        bus.instruction = 16'h7000;
        expect_state("mul_fetch2", 18);
        expect_state("mul_exec", 7);
        check("mul_src_const", 32'(bus.select_source), 32'b1011);
        expect_state("mul2", 21);
        check("mul2_alu", 32'(bus.ALU_control), 32'b0011);
        expect_state("mul_back", 17);

        // COPY R3 -> MDR (dst 101)
        bus.instruction = 16'h3305;
        expect_state("copy_fetch2", 18);
        expect_state("copy_exec", 3);
        check("copy_src", 32'(bus.select_source), 32'b0011);
        expect_state("copy2", 23);
        check("copy2_mdr_bus", 32'(bus.MDR_control), 32'b10);
        check("copy2_dst", 32'(bus.select_destination), 32'b101);
        check("copy2_alu", 32'(bus.ALU_control), 0);
        expect_state("copy_back", 17);

        // INC AC uses the ALU, DEC R3 uses the IDC
        bus.instruction = 16'hA100;
        expect_state("inc_fetch2", 18);
        expect_state("inc_exec", 10);
        check("inc_alu", 32'({bus.ALU_control, bus.IDC_control}), 32'b0111_00);
        expect_state("inc_back", 17);
        bus.instruction = 16'hB300;
        expect_state("dec_fetch2", 18);
        expect_state("dec_exec", 11);
        check("dec_idc", 32'({bus.ALU_control, bus.IDC_control}), 32'b0000_10);
        expect_state("dec_back", 17);

        // LOAD via AC address, mem_ready after 3 wait edges
        bus.instruction = 16'h1100;
        expect_state("load_fetch2", 18);
        expect_state("load_exec", 1);
        check("load_mar_ac", 32'(bus.MAR_control), 32'b01);
        expect_state("load2_entry", 24);
        check("load2_mdr_0", 32'(bus.MDR_control), 32'b01);
        for (int i = 0; i < 3; i++) begin
            expect_state("load2_wait", 24);
            check("load2_mdr_held", 32'(bus.MDR_control), 32'b01);
        end
        bus.mem_ready = 1'b1;
        expect_state("load_back", 17);
        check("load_mdr_released", 32'(bus.MDR_control), 0);
        check("load_no_mem_error", 32'(bus.mem_error), 0);
        bus.mem_ready = 1'b0;

        // STORE via {RWR,CWR}, mem_ready never arrives
        bus.instruction = 16'h2200;
        expect_state("store_fetch2", 18);
        expect_state("store_exec", 2);
        check("store_mar_write", 32'(bus.MAR_control), 32'b11);
        expect_state("store2_entry", 25);
        check("store2_write_0", 32'(bus.write_DRAM), 1);
        for (int i = 0; i < 14; i++) begin
            expect_state("store2_wait", 25);
            check("store2_write_held", 32'(bus.write_DRAM), 1);
        end
        expect_state("store_timeout", 26);
        check("timeout_mem_error", 32'(bus.mem_error), 1);
        check("timeout_write_low", 32'(bus.write_DRAM), 0);
        check("timeout_no_illegal", 32'(bus.illegal_opcode), 0);
        expect_state("error_stays", 26);

        reset = 1'b1;
        expect_state("reset_after_timeout", 16);
        check("reset_clears_mem_error", 32'(bus.mem_error), 0);
        reset = 1'b0;

        // Illegal opcode 0
        bus.instruction = 16'h0000;
        expect_state("illegal_fetch1", 17);
        expect_state("illegal_fetch2", 18);
        expect_state("illegal_error", 26);
        check("illegal_flag", 32'({bus.illegal_opcode, bus.mem_error}), 32'b10);
        expect_state("illegal_stays", 26);

        reset = 1'b1;
        expect_state("reset_after_illegal", 16);
        check("reset_clears_illegal", 32'(bus.illegal_opcode), 0);
        reset = 1'b0;

        // END holds done regardless of enable_processor
        bus.instruction = 16'hF000;
        expect_state("end_fetch1", 17);
        expect_state("end_fetch2", 18);
        expect_state("end_entry", 15);
        check("end_done", 32'(bus.done), 1);
        bus.enable_processor = 1'b0;
        for (int i = 0; i < 20; i++) begin
            expect_state("end_hold", 15);
            check("end_done_held", 32'(bus.done), 1);
        end
        reset = 1'b1;
        expect_state("reset_after_end", 16);
        check("reset_clears_done", 32'(bus.done), 0);
        reset = 1'b0;

        // Reset during STORE2 aborts the access on the same edge
        bus.enable_processor = 1'b1;
        bus.instruction      = 16'h2200;
        expect_state("abort_fetch1", 17);
        expect_state("abort_fetch2", 18);
        expect_state("abort_exec", 2);
        expect_state("abort_store2", 25);
        expect_state("abort_store2_wait", 25);
        check("abort_write_before", 32'(bus.write_DRAM), 1);
        reset = 1'b1;
        expect_state("abort_reset_state", 16);
        check("abort_write_low", 32'(bus.write_DRAM), 0);
        check("abort_flags", 32'({bus.done, bus.illegal_opcode, bus.mem_error}), 0);
        check("abort_controls", 32'({bus.MAR_control, bus.MDR_control, bus.PC_control, bus.ALU_control}), 0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
